// File: rtl/jt51_kon_pkg.sv
// rtl/jt51_kon_pkg.sv - shared constants, command type and helpers for the key-on scheduler
package jt51_kon_pkg;

    // Slot offset of each operator relative to its channel number
    localparam logic [4:0] OFS_M1 = 5'd0;
    localparam logic [4:0] OFS_M2 = 5'd8;
    localparam logic [4:0] OFS_C1 = 5'd16;
    localparam logic [4:0] OFS_C2 = 5'd24;

    // Bit positions of each operator inside a key-on mask
    localparam int MSK_M1 = 0;
    localparam int MSK_C1 = 1;
    localparam int MSK_M2 = 2;
    localparam int MSK_C2 = 3;

    typedef struct packed {
        logic [2:0] ch;
        logic [3:0] mask;
    } kon_cmd_t;

    // A channel reads as keyed on when any of its four operator slots is on
    function automatic logic [7:0] chan_or(input logic [31:0] kon);
        logic [7:0] r;
        for (int c = 0; c < 8; c++) begin
            r[c] = kon[c] | kon[c + 8] | kon[c + 16] | kon[c + 24];
        end
        return r;
    endfunction

endpackage

// File: rtl/jt51_kon_fifo.sv
// rtl/jt51_kon_fifo.sv - small synchronous FIFO holding pending key-on commands
module jt51_kon_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [6:0]               din,
    output logic [6:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [6:0]    mem_q [DEPTH];
    logic [6:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer, occupancy and storage; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/jt51_kon_sched.sv
// rtl/jt51_kon_sched.sv - frame-aligned key-on scheduler with CSM burst merge
module jt51_kon_sched
    import jt51_kon_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       zero,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_ch,
    input  logic [3:0] wr_mask,
    input  logic       csm,
    input  logic       ta_ovf,
    output logic       keyon_II,
    output logic       busy,
    output logic [7:0] kon_ch
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   kon_q, kon_d;
    logic          csm_pend_q, csm_pend_d;
    logic          csm_frame_q, csm_frame_d;
    logic [7:0]    kon_ch_q, kon_ch_d;

    logic [4:0]    slot;
    logic          commit;
    logic          push, pop;
    logic [6:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    kon_cmd_t      wr_cmd, head;

    assign slot   = zero ? 5'd0 : cnt_q;
    assign commit = cen && (slot == 5'd31);
    assign wr_cmd = '{ch: wr_ch, mask: wr_mask};
    assign head   = kon_cmd_t'(fifo_dout);
    assign push   = wr_valid && wr_ready;
    assign pop    = commit && !fifo_empty;

    jt51_kon_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_cmd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Slot rotation, frame-end commit of one command and CSM pend/frame transfer
    always_comb begin
        cnt_d       = cnt_q;
        kon_d       = kon_q;
        csm_pend_d  = csm_pend_q;
        csm_frame_d = csm_frame_q;
        if (cen) begin
            cnt_d = zero ? 5'd1 : cnt_q + 5'd1;
        end
        if (pop) begin
            kon_d[{2'b00, head.ch} + OFS_M1] = head.mask[MSK_M1];
            kon_d[{2'b00, head.ch} + OFS_M2] = head.mask[MSK_M2];
            kon_d[{2'b00, head.ch} + OFS_C1] = head.mask[MSK_C1];
            kon_d[{2'b00, head.ch} + OFS_C2] = head.mask[MSK_C2];
        end
        if (commit) begin
            csm_frame_d = csm_pend_q;
            csm_pend_d  = 1'b0;
        end
        // Set after the transfer so an overflow on the commit cycle arms the frame after next
        if (ta_ovf && csm) begin
            csm_pend_d = 1'b1;
        end
        kon_ch_d = chan_or(kon_d);
    end

    // Scheduler state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            kon_q       <= '0;
            csm_pend_q  <= 1'b0;
            csm_frame_q <= 1'b0;
            kon_ch_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            kon_q       <= kon_d;
            csm_pend_q  <= csm_pend_d;
            csm_frame_q <= csm_frame_d;
            kon_ch_q    <= kon_ch_d;
        end
    end

    assign keyon_II = kon_q[slot] | csm_frame_q;
    assign wr_ready = !fifo_full;
    assign busy     = (fifo_count != '0);
    assign kon_ch   = kon_ch_q;

endmodule

// File: tb/tb_jt51_kon_sched.sv
// tb/tb_jt51_kon_sched.sv - scoreboard bench for the key-on scheduler
module tb_jt51_kon_sched;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b0;
    logic       zero = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_ch = '0;
    logic [3:0] wr_mask = '0;
    logic       csm = 1'b0;
    logic       ta_ovf = 1'b0;
    logic       keyon_II;
    logic       busy;
    logic [7:0] kon_ch;

    jt51_kon_sched #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .zero     (zero),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_ch    (wr_ch),
        .wr_mask  (wr_mask),
        .csm      (csm),
        .ta_ovf   (ta_ovf),
        .keyon_II (keyon_II),
        .busy     (busy),
        .kon_ch   (kon_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ch;
        logic [3:0] m;
    } cmd_s;

    typedef struct {
        logic       k;
        logic       r;
        logic       b;
        logic [7:0] kc;
    } exp_s;

    exp_s exp_q[$];
    cmd_s mfifo[$];
    logic [3:0] m_mask[8];
    bit   m_pend, m_frame, m_valid;
    int   m_cnt, pos;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Operator group of a slot (slot/8) to its bit in the key-on mask
    function automatic int op_bit(input int g);
        case (g)
            0: return 0;
            1: return 2;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        mfifo.delete();
        for (int c = 0; c < 8; c++) m_mask[c] = 4'b0000;
        m_pend  = 0;
        m_frame = 0;
        m_cnt   = 0;
        pos     = 0;
    endtask

    // One clock: drive inputs, queue the expected outputs, then advance the model at the edge
    task automatic step(input bit r, input bit c, input bit v, input logic [2:0] ch,
                        input logic [3:0] m, input bit cs, input bit ovf, output bit acc);
        bit   z, push, commit;
        int   s;
        exp_s e;
        cmd_s cmd;
        z = c && (pos == 0);
        rst = r; cen = c; zero = z; wr_valid = v; wr_ch = ch; wr_mask = m;
        csm = cs; ta_ovf = ovf;
        s = z ? 0 : m_cnt;
        if (m_valid) begin
            e.k = m_mask[s % 8][op_bit(s / 8)] | m_frame;
            e.r = (mfifo.size() < DEPTH);
            e.b = (mfifo.size() != 0);
            for (int i = 0; i < 8; i++) e.kc[i] = (m_mask[i] != 4'b0000);
            exp_q.push_back(e);
        end
        push   = v && (mfifo.size() < DEPTH);
        commit = c && (s == 31);
        acc    = push && !r;
        @(posedge clk);
        if (r) begin
            model_reset();
            m_valid = 1;
        end else begin
            if (commit) begin
                if (mfifo.size() > 0) begin
                    cmd = mfifo.pop_front();
                    m_mask[cmd.ch] = cmd.m;
                end
                m_frame = m_pend;
                m_pend  = 0;
            end
            if (ovf && cs) m_pend = 1;
            if (push) begin
                cmd.ch = ch;
                cmd.m  = m;
                mfifo.push_back(cmd);
            end
            if (c) begin
                m_cnt = z ? 1 : (m_cnt + 1) % 32;
                pos   = (pos + 1) % 32;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 1, 0, 3'd0, 4'd0, 0, 0, acc);
    endtask

    task automatic goto_slot(input int k);
        bit acc;
        for (int i = 0; i < 64 && pos != k; i++) step(0, 1, 0, 3'd0, 4'd0, 0, 0, acc);
    endtask

    task automatic push_hold(input logic [2:0] ch, input logic [3:0] m, input bit c, input int maxc);
        bit acc;
        acc = 0;
        for (int i = 0; i < maxc && !acc; i++) step(0, c, 1, ch, m, 0, 0, acc);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: ch=%0d not accepted within %0d cycles, required accept", ch, maxc);
        end
    endtask

    // Scoreboard monitor: compare outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        exp_s e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp += 4;
            if (keyon_II !== e.k) begin
                n_bad++;
                $display("FAIL keyon_II @%0t: got %b required %b", $time, keyon_II, e.k);
            end
            if (wr_ready !== e.r) begin
                n_bad++;
                $display("FAIL wr_ready @%0t: got %b required %b", $time, wr_ready, e.r);
            end
            if (busy !== e.b) begin
                n_bad++;
                $display("FAIL busy @%0t: got %b required %b", $time, busy, e.b);
            end
            if (kon_ch !== e.kc) begin
                n_bad++;
                $display("FAIL kon_ch @%0t: got %h required %h", $time, kon_ch, e.kc);
            end
        end
    end

    initial begin
        bit acc;
        bit cs;
        m_valid = 0;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 0, 3'd0, 4'd0, 0, 0, acc);
        step(1, 1, 0, 3'd0, 4'd0, 0, 0, acc);

        // Idle frames after reset
        idle(64);

        // Single command pushed mid-frame
        goto_slot(10);
        push_hold(3'd3, 4'b1111, 1, 4);
        idle(70);

        // Back-to-back on/off for the same channel
        push_hold(3'd3, 4'b1111, 1, 4);
        push_hold(3'd3, 4'b0000, 1, 4);
        idle(100);

        // Fill with cen low, fifth waits for the first commit
        push_hold(3'd1, 4'b0001, 0, 4);
        push_hold(3'd2, 4'b0110, 0, 4);
        push_hold(3'd5, 4'b1010, 0, 4);
        push_hold(3'd7, 4'b1111, 0, 4);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 3'd6, 4'b0011, 0, 0, acc);
        push_hold(3'd6, 4'b0011, 1, 40);
        idle(170);

        // CSM overflow arms one all-on frame; ignored when csm is off
        goto_slot(5);
        step(0, 1, 0, 3'd0, 4'd0, 1, 1, acc);
        idle(70);
        goto_slot(5);
        step(0, 1, 0, 3'd0, 4'd0, 0, 1, acc);
        idle(70);
        // Overflow exactly on the commit cycle
        goto_slot(31);
        step(0, 1, 0, 3'd0, 4'd0, 1, 1, acc);
        idle(70);

        // All channels on, two queued, then reset mid-frame
        for (int c = 0; c < 8; c++) push_hold(3'(c), 4'b1111, 1, 200);
        idle(200);
        push_hold(3'd0, 4'b0000, 1, 4);
        push_hold(3'd1, 4'b0000, 1, 4);
        goto_slot(20);
        step(1, 1, 0, 3'd0, 4'd0, 0, 0, acc);
        idle(100);

        // Randomized traffic
        cs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 300) == 0) cs = $urandom_range(0, 1);
            step(($urandom_range(0, 799) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)),
                 cs,
                 ($urandom_range(0, 99) == 0),
                 acc);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jt51_kon_sched.md
Name: jt51_kon_sched

Overview:
Key-on scheduler for the 32-slot time-multiplexed envelope generator. It buffers key-on/off register writes (channel plus 4-operator mask) in a small FIFO and commits them only at frame boundaries, so all operators of a channel change state in the same sample frame. It merges CSM (timer-A overflow) key-on bursts and presents the per-slot keyon_II bit, aligned with the envelope generator's stage II slot rotation.

Parameters:
FIFO_DEPTH, 4, number of buffered key-on commands (power of two, ≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cen  in  1  clock enable; slot rotation, commit and CSM logic advance only when high
zero  in  1  high on the cen cycle whose stage-II slot is slot 0
wr_valid  in  1  key-on command offered
wr_ready  out  1  FIFO can accept a command
wr_ch  in  3  target channel 0..7
wr_mask  in  4  operator enables: [0]=M1, [1]=C1, [2]=M2, [3]=C2
csm  in  1  CSM mode enable (level)
ta_ovf  in  1  timer-A overflow pulse, one clk wide
keyon_II  out  1  key-on state of the slot currently at stage II
busy  out  1  FIFO non-empty
kon_ch  out  8  per-channel OR of committed kon bits (status readback)

Behaviour:
- Reset: FIFO emptied; kon[31:0]=0; csm_pend=0; csm_frame=0; slot counter=0; keyon_II=0, busy=0, kon_ch=0, wr_ready=1. A reset mid-frame discards pending commands and releases all slots (keyon_II=0 on the next cycle).
- Slot counter cnt[4:0], on cen: zero ? cnt<=1 : cnt<=cnt+1 (wraps 31→0). Current slot s = zero ? 0 : cnt.
- Slot mapping: M1 = ch, M2 = ch+8, C1 = ch+16, C2 = ch+24.
- keyon_II = kon[s] | csm_frame. The output is combinational from registers; it carries no extra latency versus zero.
- Handshake: a push occurs when wr_valid && wr_ready, on any clk and independent of cen. wr_ready = !full. A full FIFO deasserts ready even when a pop occurs in the same cycle. Data on wr_ch and wr_mask is sampled only on the push cycle.
- Commit point: the cen cycle where s==31 (frame end). At that cycle:
  - If the FIFO is non-empty, pop the head and replace the 4 kon bits of its channel with its mask. Other channels are unchanged.
  - At most one command commits per frame. Later commands wait for later frames.
  - csm_frame <= csm_pend, and csm_pend <= 0.
- New kon and csm_frame values take effect from slot 0 of the next frame. No slot ever sees a partial channel update.
- CSM:
  - ta_ovf && csm sets csm_pend. An overflow with csm=0 is ignored.
  - csm_frame forces every slot on for exactly one frame and is cleared at the following commit point unless re-armed.
  - An overflow on the same cycle as the commit point arms the frame after next (pend set after the transfer).
- Simultaneous push and pop: both occur, and occupancy is unchanged.
- busy = FIFO count≠0. kon_ch[c] = |{kon[c],kon[c+8],kon[c+16],kon[c+24]}, registered and updated with kon.
- cen low: no commit and no counter advance. Pushes are still accepted.

Decomposition:
- Package jt51_kon_pkg:
  - slot offset constants OFS_M1=0, OFS_M2=8, OFS_C1=16, OFS_C2=24
  - mask bit indices
  - command struct {ch[2:0], mask[3:0]}
- Sub-module jt51_kon_fifo: synchronous FIFO (width 7, depth FIFO_DEPTH) with push/pop/full/empty/count. The top level holds the slot counter, commit and CSM logic.

Test Plan:
- Reset then free-run 64 cen cycles with zero every 32 → keyon_II=0 every slot, wr_ready=1, busy=0.
- Push ch=3, mask=4'b1111 at slot 10 → kon unchanged through slot 31. From the next frame, keyon_II=1 at slots 3, 11, 19, 27 only. kon_ch=8'h08.
- Push ch=3 mask=1111, then ch=3 mask=0000 back-to-back → frame N+1 shows slots 3/11/19/27 on, frame N+2 shows all off. busy drops after the second commit.
- Push 5 commands with cen held low → 4 accepted, wr_ready=0 on the 5th until cen resumes and the first commit pops. Contents commit in FIFO order.
- csm=1, ta_ovf at slot 5 → next frame keyon_II=1 on all 32 slots, the frame after reverts to kon. With csm=0 the same ta_ovf gives no effect.
- Assert rst at slot 20 with 2 queued commands and kon=8'hFF channels on → keyon_II=0 next cycle, busy=0, and nothing commits after rst is released.
